// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 800x600@72 Hz VGA path.
// The bit-map/colour stage uses the same constants so both stages agree on the geometry.
package vga_pkg;

  localparam int unsigned COL_W   = 11;
  localparam int unsigned DATA_W  = 16;

  localparam int unsigned CLK_DIV = 2;

  localparam int unsigned H_VIS   = 800;
  localparam int unsigned H_FP    = 56;
  localparam int unsigned H_SYNC  = 120;
  localparam int unsigned H_BP    = 64;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS   = 600;
  localparam int unsigned V_FP    = 37;
  localparam int unsigned V_SYNC  = 6;
  localparam int unsigned V_BP    = 23;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b1;

  // True when pos lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [COL_W-1:0] pos,
                                     input logic [COL_W-1:0] lo,
                                     input logic [COL_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/pix_clk_div.sv
// Pixel-rate divider: adv is the combinational terminal count used to step the
// raster counters; pix_tick is its registered copy, so pix_tick is high in the
// same clk in which the counters show their new value.
module pix_clk_div #(
  parameter int unsigned CLK_DIV = vga_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic adv,
  output logic pix_tick
);
  import vga_pkg::*;

  localparam int unsigned        DIV_W    = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 32'd1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q, pix_tick_d;

  // Next divider count and terminal-count decode.
  always_comb begin
    adv        = (div_q == DIV_LAST);
    pix_tick_d = adv;
    if (adv) begin
      div_d = DIV_W'(0);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider and pixel-tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= DIV_W'(0);
      pix_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, video-active flag, syncs delayed one
// pixel to line up with the registered colour stage, and a frame-stable copy of
// data_in that only changes on the last pixel of a frame.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int unsigned H_VIS    = vga_pkg::H_VIS,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_VIS    = vga_pkg::V_VIS,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter logic        SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [vga_pkg::DATA_W-1:0]  data_in,
  output logic                        pix_tick,
  output logic [vga_pkg::COL_W-1:0]   column,
  output logic [vga_pkg::COL_W-1:0]   row,
  output logic                        video_on,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        frame_start,
  output logic [vga_pkg::DATA_W-1:0]  data_out
);
  import vga_pkg::*;

  localparam int unsigned HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [COL_W-1:0] H_LAST  = COL_W'(HT - 32'd1);
  localparam logic [COL_W-1:0] V_LAST  = COL_W'(VT - 32'd1);
  localparam logic [COL_W-1:0] H_VIS_C = COL_W'(H_VIS);
  localparam logic [COL_W-1:0] V_VIS_C = COL_W'(V_VIS);
  localparam logic [COL_W-1:0] HS_BEG  = COL_W'(H_VIS + H_FP);
  localparam logic [COL_W-1:0] HS_END  = COL_W'(H_VIS + H_FP + H_SYNC - 32'd1);
  localparam logic [COL_W-1:0] VS_BEG  = COL_W'(V_VIS + V_FP);
  localparam logic [COL_W-1:0] VS_END  = COL_W'(V_VIS + V_FP + V_SYNC - 32'd1);

  logic                adv;
  logic                line_end, frame_end;
  logic [COL_W-1:0]    h_q, h_d, v_q, v_d;
  logic                video_on_q, video_on_d;
  logic                hsync_q, hsync_d, vsync_q, vsync_d;
  logic                frame_start_q, frame_start_d;
  logic [DATA_W-1:0]   data_q, data_d;

  pix_clk_div #(.CLK_DIV(CLK_DIV)) u_pix_clk_div (
    .clk      (clk),
    .reset    (reset),
    .adv      (adv),
    .pix_tick (pix_tick)
  );

  // Raster step: counters, video flag and one-pixel-delayed syncs advance
  // together on the pixel enable; the display word is captured on the last pixel.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    data_d        = data_q;
    line_end      = (h_q == H_LAST);
    frame_end     = line_end && (v_q == V_LAST);
    if (adv) begin
      if (line_end) begin
        h_d = COL_W'(0);
        if (v_q == V_LAST) begin
          v_d = COL_W'(0);
        end else begin
          v_d = v_q + COL_W'(1);
        end
      end else begin
        h_d = h_q + COL_W'(1);
      end
      video_on_d = (h_d < H_VIS_C) && (v_d < V_VIS_C);
      // Decoding the pre-advance position is what delays the syncs by one pixel.
      hsync_d    = in_window(h_q, HS_BEG, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d    = in_window(v_q, VS_BEG, VS_END) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = frame_end;
      if (frame_end) begin
        data_d = data_in;
      end else begin
        data_d = data_q;
      end
    end else begin
      frame_start_d = 1'b0;
    end
  end

  // Raster state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q           <= COL_W'(0);
      v_q           <= COL_W'(0);
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      data_q        <= 16'h0000;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      data_q        <= data_d;
    end
  end

  assign column      = h_q;
  assign row         = v_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign data_out    = data_q;

endmodule
